// File: rtl/key_repeat_filter.sv
// key_repeat_filter: conditions the raw USB keycode from the NIOS into clean
// one-cycle key events with debounce and optional auto-repeat.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no key held, cur_key is 0
// DEBOUNCE| candidate keycode waiting to stay stable for STABLE_CYCLES
// HELD    | key accepted; counting REPEAT_DELAY when repeat_en is set
// REPEAT  | auto-repeating every REPEAT_RATE clocks
module key_repeat_filter #(
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       repeat_en,
  output logic [7:0] key,
  output logic       key_valid,
  output logic [7:0] cur_key
);

  localparam int MAX_AB = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int MAX_T  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int CNT_W  = (MAX_T > 2) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] ST_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DL_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RT_TC  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_MX = CNT_W'(MAX_T - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REPEAT   = 2'd3;

  logic [1:0]       state, state_n;
  logic [7:0]       keycode_q;
  logic [7:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [7:0]       cur_key_n;
  logic             ev;
  logic [7:0]       ev_key;

  // Counter never wraps past the largest terminal value.
  assign cnt_inc = (cnt == CNT_MX) ? cnt : cnt + 1'b1;

  // Next-state and event decode; release/change outrank repeat expiry.
  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    cur_key_n = cur_key;
    ev        = 1'b0;
    ev_key    = 8'h00;
    case (state)
      IDLE: begin
        cur_key_n = 8'h00;
        if (keycode_q != 8'h00) begin
          state_n = DEBOUNCE;
          cand_n  = keycode_q;
          cnt_n   = '0;
        end
      end
      DEBOUNCE: begin
        if (keycode_q == 8'h00) begin
          state_n   = IDLE;
          cur_key_n = 8'h00;
          cnt_n     = '0;
        end else if (keycode_q != cand) begin
          cand_n = keycode_q;
          cnt_n  = '0;
        end else if (cnt == ST_TC) begin
          ev        = 1'b1;
          ev_key    = cand;
          cur_key_n = cand;
          state_n   = HELD;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HELD, REPEAT: begin
        if (keycode_q == 8'h00) begin
          state_n   = IDLE;
          cur_key_n = 8'h00;
          cnt_n     = '0;
        end else if (keycode_q != cur_key) begin
          // cur_key holds the old key until the new press is accepted
          state_n = DEBOUNCE;
          cand_n  = keycode_q;
          cnt_n   = '0;
        end else if (!repeat_en) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if ((state == HELD) && (cnt == DL_TC)) begin
          ev      = 1'b1;
          ev_key  = cur_key;
          state_n = REPEAT;
          cnt_n   = '0;
        end else if ((state == REPEAT) && (cnt == RT_TC)) begin
          ev     = 1'b1;
          ev_key = cur_key;
          cnt_n  = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n   = IDLE;
        cur_key_n = 8'h00;
        cnt_n     = '0;
      end
    endcase
  end

  // Register input keycode, FSM state and the event/held-key outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      keycode_q <= 8'h00;
      cand      <= 8'h00;
      cnt       <= '0;
      cur_key   <= 8'h00;
      key       <= 8'h00;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      keycode_q <= keycode;
      cand      <= cand_n;
      cnt       <= cnt_n;
      cur_key   <= cur_key_n;
      key       <= ev ? ev_key : 8'h00;
      key_valid <= ev;
    end
  end

endmodule
